// File: rtl/instr_fetch_queue.sv
// In-order instruction fetch: credit-limited requests, response FIFO, redirect flush, EBREAK halt.
// Optional FETCH_BYPASS_EN: an empty FIFO lets a response go straight to the control unit.

module instr_fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            halted
);
  localparam int unsigned     AW     = $clog2(DEPTH);
  localparam int unsigned     CW     = AW + 1;
  localparam logic [CW:0]     CAP    = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] EBREAK = XLEN'(32'h0010_0073);
  localparam logic [XLEN-1:0] STEP   = XLEN'(4);

  logic [XLEN-1:0] fetch_pc, rsp_pc, redirect_target;
  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [XLEN-1:0] fifo_pc [DEPTH];
  logic [AW-1:0]   head, tail;
  logic [CW-1:0]   count, outstanding, drop, outstanding_next;
  logic            run, halted_q;
  logic            req_fire, rsp_fire, redir, fifo_empty, bypass;
  logic            consume, pop, keep, push;

  assign redirect_target  = redirect_pc & ~XLEN'(3);
  assign fifo_empty       = (count == '0);
  assign req_fire         = mem_req_valid && mem_req_ready;
  // Responses with nothing outstanding are stale (e.g. issued before a reset).
  assign rsp_fire         = mem_rsp_valid && (outstanding != '0);
  assign redir            = redirect_valid && !halted_q;
  assign outstanding_next = outstanding + CW'(req_fire) - CW'(rsp_fire);

  // Outstanding requests plus buffered entries never exceed DEPTH, so a push never meets a full FIFO.
  assign mem_req_valid = run && !halted_q && (({1'b0, outstanding} + {1'b0, count}) < CAP);
  assign mem_req_addr  = fetch_pc;

`ifdef FETCH_BYPASS_EN
  assign bypass = fifo_empty && (drop == '0) && !halted_q && rsp_fire && inst_ready;
`else
  assign bypass = 1'b0;
`endif

  assign inst_valid = !halted_q && (!fifo_empty || bypass);
  assign halted     = halted_q;

  always_comb begin
    inst_data = '0;
    inst_pc   = '0;
    if (!fifo_empty) begin
      inst_data = fifo_data[head];
      inst_pc   = fifo_pc[head];
    end else if (bypass) begin
      inst_data = mem_rsp_data;
      inst_pc   = rsp_pc;
    end
  end

  assign consume = inst_valid && inst_ready;
  assign pop     = consume && !fifo_empty;
  // A response landing in a redirect cycle belongs to the old path.
  assign keep    = rsp_fire && (drop == '0) && !halted_q && !redir;
  assign push    = keep && !bypass;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run         <= 1'b0;
      halted_q    <= 1'b0;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      run         <= 1'b1;
      outstanding <= outstanding_next;
      if (consume && inst_data == EBREAK) halted_q <= 1'b1;
      if (redir) begin
        // Everything still in flight after this cycle is wrong-path, including a same-cycle request.
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        fetch_pc <= redirect_target;
        rsp_pc   <= redirect_target;
        drop     <= outstanding_next;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + STEP;
        if (keep) rsp_pc <= rsp_pc + STEP;
        if (rsp_fire && drop != '0) drop <= drop - CW'(1);
        if (push) tail <= tail + AW'(1);
        if (pop) head <= head + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[tail] <= mem_rsp_data;
      fifo_pc[tail]   <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: epoch-tagged memory model, expected-instruction queue.
module tb_instr_fetch_queue;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halted;

  instr_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  bit          mem_rdy_en = 1'b0;
  bit          inst_rdy_en = 1'b0;
  bit          redir_req = 1'b0;
  logic [31:0] redir_tgt = '0;
  int          lat = 1;
  int          cyc = 0;
  int          epoch = 0;
  logic [31:0] exp_fetch = '0;
  bit          halt_m = 1'b0;
  bit          halt_chk = 1'b0;
  bit          ebreak_en = 1'b0;
  logic [31:0] ebreak_addr = '0;
  int          req_cnt = 0;
  logic [31:0] base;
  req_t        inflight[$];
  exp_t        exp_q[$];
  logic [31:0] popped[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] addr);
    if (ebreak_en && addr == ebreak_addr) return EBREAK;
    return 32'h0000_0013 | (addr << 10);
  endfunction

  // One clock: drive at negedge, observe handshakes 1ns later, commit at posedge.
  task automatic step();
    req_t r;
    exp_t e;
    bit   was_halted;
    bit   ebreak_pop;
    @(negedge clk);
    mem_req_ready  = mem_rdy_en;
    inst_ready     = inst_rdy_en;
    redirect_valid = redir_req;
    redirect_pc    = redir_tgt;
    redir_req      = 1'b0;
    if (inflight.size() > 0 && inflight[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = word(inflight[0].addr);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'hDEAD_BEEF;
    end
    #1;
    was_halted = halt_m;
    ebreak_pop = 1'b0;
    if (halt_chk) begin
      check("halted_next", 32'(halted), 32'd1);
      halt_chk = 1'b0;
    end
    if (was_halted) begin
      check("halt_req_valid", 32'(mem_req_valid), 32'd0);
      check("halt_inst_valid", 32'(inst_valid), 32'd0);
    end
    if (inst_valid && inst_ready) begin
      popped.push_back(inst_pc);
      if (exp_q.size() == 0) begin
        check("inst_spurious", 32'(inst_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("inst_pc", inst_pc, e.pc);
        check("inst_data", inst_data, e.data);
        ebreak_pop = (e.data == EBREAK);
      end
    end
    if (mem_rsp_valid) begin
      r = inflight.pop_front();
      if (r.epoch == epoch && !was_halted) exp_q.push_back('{pc: r.addr, data: mem_rsp_data});
    end
    if (mem_req_valid && mem_req_ready) begin
      check("req_addr", mem_req_addr, exp_fetch);
      inflight.push_back('{addr: mem_req_addr, epoch: epoch, due: cyc + lat});
      exp_fetch = exp_fetch + 32'd4;
      req_cnt++;
    end
    if (redirect_valid && !was_halted) begin
      epoch++;
      exp_fetch = {redirect_pc[31:2], 2'b00};
      exp_q.delete();
    end
    if (ebreak_pop) begin
      halt_m   = 1'b1;
      halt_chk = 1'b1;
      exp_q.delete();
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic drain();
    mem_rdy_en  = 1'b0;
    inst_rdy_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (inflight.size() == 0 && exp_q.size() == 0) break;
      step();
    end
    check("drain", 32'(inflight.size() + exp_q.size()), 32'd0);
  endtask

  task automatic reset_checks();
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_req_addr", mem_req_addr, 32'h0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst_data", inst_data, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_halted", 32'(halted), 32'd0);
  endtask

  // Anything the memory still owes belongs to a dead epoch and is returned right away.
  task automatic pulse_reset();
    #2 reset = 1'b0;
    #1 reset_checks();
    epoch++;
    foreach (inflight[i]) inflight[i].due = 0;
    exp_q.delete();
    exp_fetch = 32'h0;
    halt_m    = 1'b0;
    halt_chk  = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    pulse_reset();

    // Straight-line fetch, 1-cycle memory.
    mem_rdy_en = 1'b1; inst_rdy_en = 1'b1; lat = 1;
    popped.delete();
    repeat (12) step();
    drain();
    check("seq_npop", 32'(popped.size() >= 3), 32'd1);
    check("seq_pc0", popped[0], 32'h0);
    check("seq_pc1", popped[1], 32'h4);
    check("seq_pc2", popped[2], 32'h8);

    // Consumer stalled: credit cap of 4 requests.
    inst_rdy_en = 1'b0; mem_rdy_en = 1'b1; lat = 1; req_cnt = 0;
    repeat (10) step();
    check("bp_reqs", 32'(req_cnt), 32'd4);
    #1 check("bp_stall", 32'(mem_req_valid), 32'd0);
    inst_rdy_en = 1'b1;
    step();
    inst_rdy_en = 1'b0;
    #1 check("bp_resume", 32'(mem_req_valid), 32'd1);
    drain();

    // Redirect with two responses outstanding.
    popped.delete();
    lat = 3; mem_rdy_en = 1'b1; inst_rdy_en = 1'b1;
    step();
    step();
    check("redir_out", 32'(inflight.size()), 32'd2);
    mem_rdy_en = 1'b0; redir_tgt = 32'h103; redir_req = 1'b1;
    step();
    #1 check("redir_inst_valid", 32'(inst_valid), 32'd0);
    mem_rdy_en = 1'b1;
    repeat (10) step();
    drain();
    check("redir_first_pc", popped[0], 32'h100);

    // Redirect, dequeue, response and request all in one cycle.
    popped.delete();
    base = exp_fetch;
    lat = 1; inst_rdy_en = 1'b0; mem_rdy_en = 1'b1;
    repeat (3) step();
    inst_rdy_en = 1'b1; redir_tgt = 32'h200; redir_req = 1'b1;
    step();
    #1 check("flush_inst_valid", 32'(inst_valid), 32'd0);
    repeat (8) step();
    drain();
    check("flush_head", popped[0], base);
    check("flush_next", popped[1], 32'h200);

    // EBREAK at 0x8 halts; a later redirect is ignored.
    mem_rdy_en = 1'b0; redir_tgt = 32'h0; redir_req = 1'b1;
    step();
    popped.delete();
    ebreak_en = 1'b1; ebreak_addr = 32'h8;
    mem_rdy_en = 1'b1; inst_rdy_en = 1'b1; lat = 1;
    repeat (10) step();
    redir_tgt = 32'h300; redir_req = 1'b1;
    step();
    repeat (3) step();
    drain();
    #1;
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_stay_req", 32'(mem_req_valid), 32'd0);
    check("halt_npop", 32'(popped.size()), 32'd3);
    check("halt_last_pc", popped[2], 32'h8);
    ebreak_en = 1'b0;

    // Reset clears the halt, then reset mid-burst with three outstanding.
    pulse_reset();
    mem_rdy_en = 1'b1; inst_rdy_en = 1'b1; lat = 6;
    for (int i = 0; i < 10 && inflight.size() < 3; i++) step();
    check("burst_out", 32'(inflight.size()), 32'd3);
    mem_rdy_en = 1'b0;
    pulse_reset();
    repeat (4) step();
    #1 check("stale_inst_valid", 32'(inst_valid), 32'd0);
    popped.delete();
    mem_rdy_en = 1'b1; lat = 1;
    repeat (10) step();
    drain();
    check("post_rst_pc0", popped[0], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Instruction fetch stage directly upstream of the RV32 control unit.
- Issues in-order word fetches to instruction memory over a valid/ready request channel with fixed-order, unbounded-latency responses.
- Buffers returned instructions with their PCs in a small FIFO and hands them to the control unit over a valid/ready channel.
- Handles branch/jump redirects from the control unit and latches a halt on EBREAK.

Parameters:
XLEN, 32, data/address width
DEPTH, 4, FIFO entries; also the cap on outstanding requests plus occupied entries (power of 2, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
mem_req_valid  out  1  fetch request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  XLEN  word address of request, bits[1:0] always 0
mem_rsp_valid  in  1  response word valid, in request order
mem_rsp_data  in  XLEN  instruction word
inst_valid  out  1  instruction available to control unit
inst_ready  in  1  control unit consumes instruction
inst_data  out  XLEN  head instruction
inst_pc  out  XLEN  PC of head instruction
redirect_valid  in  1  control-flow redirect (taken branch/jump)
redirect_pc  in  XLEN  new PC; bits[1:0] ignored, forced to 0
halted  out  1  EBREAK consumed; fetch stopped

Behaviour:
- State: fetch_pc, rsp_pc, FIFO (data+pc), outstanding count, drop count, halted flag.
- Reset (reset=0, async):
  - fetch_pc=rsp_pc=RESET_PC; FIFO empty; outstanding=drop=0; halted=0.
  - Outputs: mem_req_valid=0, mem_req_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, halted=0.
- Request:
  - mem_req_valid = !halted && (outstanding + occupancy) < DEPTH; mem_req_addr = fetch_pc.
  - On handshake, fetch_pc += 4 (wraps modulo 2^XLEN) and outstanding += 1.
- Response:
  - Each mem_rsp_valid decrements outstanding.
  - If drop>0 or halted, the word is discarded and drop decrements (saturating at 0).
  - Otherwise the word is pushed with pc=rsp_pc, then rsp_pc += 4.
  - mem_rsp_valid with outstanding=0 is ignored.
  - Credit scheme guarantees no push on full.
- Delivery:
  - inst_valid = FIFO non-empty && !halted; inst_data/inst_pc = head entry.
  - Pop on inst_valid && inst_ready.
  - Latency: response at cycle N gives inst_valid at N+1 at the earliest.
- Redirect (redirect_valid=1, not halted):
  - Any same-cycle dequeue handshake completes first.
  - Then the FIFO is flushed, fetch_pc=rsp_pc={redirect_pc[31:2],2'b00}, and drop = in-flight count after this cycle's request and response events.
  - A request handshaked in the redirect cycle is counted into drop and uses the old address.
  - A response arriving in the redirect cycle is discarded.
  - inst_valid=0 the cycle after a redirect.
- Halt:
  - Dequeue of mem_rsp_data==32'h0010_0073 (EBREAK) sets halted the next cycle.
  - halted is sticky until reset; mem_req_valid and inst_valid are forced 0.
  - Later responses are drained and discarded; redirects are ignored.
- Reset mid-operation: all state cleared immediately; in-flight responses that arrive after reset release are ignored (outstanding=0).

Optional Feature:
FETCH_BYPASS_EN
- Defined: when the FIFO is empty, drop=0, !halted, mem_rsp_valid=1 and inst_ready=1, the response is driven combinationally onto inst_data/inst_pc with inst_valid=1 and not written to the FIFO. Zero-cycle latency.
- Undefined: all responses go through the FIFO; minimum latency is 1 cycle.

Test Plan:
- Reset release, memory always ready, 1-cycle responses -> requests at 0x0,0x4,0x8,...; inst_pc sequence 0x0,0x4,0x8 with matching data.
- inst_ready held 0, DEPTH=4 -> exactly 4 requests issued, then mem_req_valid=0; resumes 1 cycle after the first pop.
- Redirect to 0x103 with 2 responses outstanding -> both dropped; next mem_req_addr=0x100; first delivered inst_pc=0x100.
- Redirect, dequeue and mem_rsp_valid in the same cycle -> head consumed once; response discarded; no stale PC delivered afterwards.
- EBREAK 0x00100073 at pc 0x8 consumed -> halted=1 next cycle; mem_req_valid=0 and inst_valid=0 thereafter; later redirect ignored.
- reset pulled low mid-burst with 3 outstanding -> outputs at reset values immediately; after release the first request is at RESET_PC and stale responses are ignored.
